// File: rtl/uart_rx_if.sv
// Byte handshake and status bundle between the UART receiver and its consumer.
// The receiver is the master: it drives data/status and listens for ack.
interface uart_rx_if;
  logic [7:0] byte_received;
  logic       valid;
  logic       ack;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  modport master (
    output byte_received,
    output valid,
    output framing_error,
    output overrun,
    output busy,
    input  ack
  );

  modport slave (
    input  byte_received,
    input  valid,
    input  framing_error,
    input  overrun,
    input  busy,
    output ack
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, 3-sample mid-bit majority vote,
// valid/ack delivery with framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned clocks_per_bit = 16
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     pin,
  uart_rx_if.master rx_if
);

  localparam int unsigned Mid  = clocks_per_bit / 2;
  localparam int unsigned CntW = $clog2(clocks_per_bit);
  localparam logic [CntW-1:0] MidM1   = CntW'(Mid - 1);
  localparam logic [CntW-1:0] MidC    = CntW'(Mid);
  localparam logic [CntW-1:0] MidP1   = CntW'(Mid + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(clocks_per_bit - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  state_e          state_q, state_d;
  logic            sync_q, rx_s_q;
  logic [CntW-1:0] clocks_q, clocks_d;
  logic [2:0]      bit_index_q, bit_index_d;
  logic [7:0]      shift_q, shift_d;
  logic [1:0]      samp_q, samp_d;
  logic [7:0]      byte_q, byte_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            ovr_q, ovr_d;

  logic last_clk, at_vote, vote, deliver;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      clocks_q    <= '0;
      bit_index_q <= '0;
      shift_q     <= '0;
      samp_q      <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      fe_q        <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      sync_q      <= pin;
      rx_s_q      <= sync_q;
      state_q     <= state_d;
      clocks_q    <= clocks_d;
      bit_index_q <= bit_index_d;
      shift_q     <= shift_d;
      samp_q      <= samp_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      fe_q        <= fe_d;
      ovr_q       <= ovr_d;
    end
  end

  assign last_clk = (clocks_q == LastCnt);
  assign at_vote  = (clocks_q == MidP1);
  // Third sample is the live rx_s of the mid+1 cycle.
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s_q) | (samp_q[0] & rx_s_q);

  always_comb begin
    state_d     = state_q;
    clocks_d    = clocks_q;
    bit_index_d = bit_index_q;
    shift_d     = shift_q;
    samp_d      = samp_q;
    byte_d      = byte_q;
    valid_d     = valid_q;
    fe_d        = 1'b0;
    ovr_d       = 1'b0;
    deliver     = 1'b0;

    if (state_q == StStart || state_q == StData || state_q == StStop) begin
      clocks_d = last_clk ? '0 : clocks_q + 1'b1;
      if (clocks_q == MidM1 || clocks_q == MidC) begin
        samp_d = {samp_q[0], rx_s_q};
      end
    end

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d  = StStart;
          clocks_d = '0;
        end
      end
      StStart: begin
        if (at_vote && vote) begin
          state_d  = StIdle;
          clocks_d = '0;
        end else if (last_clk) begin
          state_d     = StData;
          bit_index_d = '0;
        end
      end
      StData: begin
        if (at_vote) begin
          shift_d = {vote, shift_q[7:1]};
        end
        if (last_clk) begin
          if (bit_index_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_index_d = bit_index_q + 3'd1;
          end
        end
      end
      StStop: begin
        // Leave at the vote so the receiver re-arms half a bit early.
        if (at_vote) begin
          clocks_d = '0;
          if (vote) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            fe_d    = 1'b1;
            state_d = StWaitHigh;
          end
        end
      end
      StWaitHigh: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rx_if.ack && valid_q) begin
      valid_d = 1'b0;
    end
    if (deliver) begin
      valid_d = 1'b1;
      byte_d  = shift_q;
      ovr_d   = valid_q && !rx_if.ack;
    end
  end

  assign rx_if.byte_received = byte_q;
  assign rx_if.valid         = valid_q;
  assign rx_if.framing_error = fe_q;
  assign rx_if.overrun       = ovr_q;
  assign rx_if.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes are queued as frames are driven and
// popped by a monitor whenever the receiver delivers a byte.
module tb_uart_rx;

  logic clock;
  logic reset;
  logic pin;

  uart_rx_if rx_if ();

  uart_rx #(.clocks_per_bit(16)) dut (
    .clock (clock),
    .reset (reset),
    .pin   (pin),
    .rx_if (rx_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int fe_count = 0;
  int ov_count = 0;

  logic [7:0] exp_q[$];
  logic [7:0] byte_prev  = '0;
  logic       valid_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit period starting at a falling clock edge; optional one-cycle
  // high spike lands in the receiver's clocks==mid sample.
  task automatic drive_bit(input logic v, input bit spike);
    for (int k = 0; k < 16; k++) begin
      pin = (spike && k == 9) ? 1'b1 : v;
      @(negedge clock);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit spike);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i], spike);
    drive_bit(stop, 1'b0);
  endtask

  // Delivery monitor: a rising valid or a changed byte marks a new delivery.
  always begin
    @(posedge clock);
    #1;
    if (!reset) begin
      if ((rx_if.valid && !valid_prev) || (rx_if.byte_received !== byte_prev)) begin
        if (exp_q.size() == 0) begin
          check("sb_nonempty_on_delivery", 32'(exp_q.size() != 0), 32'd1);
        end else begin
          check("sb_byte", 32'(rx_if.byte_received), 32'(exp_q.pop_front()));
        end
      end
      if (rx_if.framing_error) fe_count++;
      if (rx_if.overrun) ov_count++;
    end
    byte_prev  = rx_if.byte_received;
    valid_prev = rx_if.valid;
  end

  initial begin
    int busy_cnt;
    int fe_base;
    int ov_base;
    logic seen_flag;

    reset = 1'b1;
    pin = 1'b1;
    rx_if.ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_byte", 32'(rx_if.byte_received), 32'h0);
    check("rst_valid", 32'(rx_if.valid), 32'h0);
    check("rst_fe", 32'(rx_if.framing_error), 32'h0);
    check("rst_overrun", 32'(rx_if.overrun), 32'h0);
    check("rst_busy", 32'(rx_if.busy), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // Good frame with exact delivery latency.
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (156) @(posedge clock);
        #1;
        check("valid_before_delivery", 32'(rx_if.valid), 32'h0);
        check("busy_in_stop", 32'(rx_if.busy), 32'h1);
        @(posedge clock);
        #1;
        check("valid_at_delivery", 32'(rx_if.valid), 32'h1);
        check("byte_a5", 32'(rx_if.byte_received), 32'hA5);
        check("busy_after_stop_vote", 32'(rx_if.busy), 32'h0);
      end
    join
    rx_if.ack = 1'b1;
    @(posedge clock);
    #1;
    check("valid_cleared_by_ack", 32'(rx_if.valid), 32'h0);
    @(negedge clock);
    rx_if.ack = 1'b0;
    @(negedge clock);
    rx_if.ack = 1'b1;
    @(negedge clock);
    rx_if.ack = 1'b0;
    check("ack_when_idle_ignored", 32'(rx_if.valid), 32'h0);
    repeat (4) @(negedge clock);

    // Glitch: 4-clock low pulse must abort at the start-bit vote.
    seen_flag = 1'b0;
    busy_cnt = 0;
    fork
      begin
        pin = 1'b0;
        repeat (4) @(negedge clock);
        pin = 1'b1;
      end
      begin
        repeat (30) begin
          @(posedge clock);
          #1;
          busy_cnt += int'(rx_if.busy);
          seen_flag |= rx_if.valid | rx_if.framing_error | rx_if.overrun;
        end
      end
    join
    check("glitch_busy_cycles", 32'(busy_cnt), 32'd10);
    check("glitch_no_outputs", 32'(seen_flag), 32'h0);
    @(negedge clock);

    // Framing error followed by a held-low break.
    fe_base = fe_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clock);
    check("break_holds_busy", 32'(rx_if.busy), 32'h1);
    pin = 1'b1;
    repeat (6) @(negedge clock);
    check("fe_single_pulse", 32'(fe_count - fe_base), 32'd1);
    check("fe_no_valid", 32'(rx_if.valid), 32'h0);
    check("fe_rearmed_idle", 32'(rx_if.busy), 32'h0);

    // Noise tolerance: single-cycle spikes in every data bit.
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, 1'b1);
    check("noise_byte", 32'(rx_if.byte_received), 32'h00);
    check("noise_valid", 32'(rx_if.valid), 32'h1);
    rx_if.ack = 1'b1;
    @(negedge clock);
    rx_if.ack = 1'b0;
    repeat (4) @(negedge clock);

    // Overrun: two back-to-back frames, no ack.
    ov_base = ov_count;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("overrun_pulse", 32'(ov_count - ov_base), 32'd1);
    check("overrun_byte", 32'(rx_if.byte_received), 32'h22);
    check("overrun_valid", 32'(rx_if.valid), 32'h1);
    rx_if.ack = 1'b1;
    @(negedge clock);
    rx_if.ack = 1'b0;
    repeat (4) @(negedge clock);

    // Same again with ack coinciding with the second delivery.
    ov_base = ov_count;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1, 1'b0);
      begin
        repeat (156) @(posedge clock);
        @(negedge clock);
        rx_if.ack = 1'b1;
        @(posedge clock);
        #1;
        check("simul_valid", 32'(rx_if.valid), 32'h1);
        check("simul_no_overrun", 32'(rx_if.overrun), 32'h0);
        @(negedge clock);
        rx_if.ack = 1'b0;
      end
    join
    check("simul_overrun_count", 32'(ov_count - ov_base), 32'd0);
    check("simul_byte", 32'(rx_if.byte_received), 32'h22);
    check("simul_valid_held", 32'(rx_if.valid), 32'h1);
    repeat (4) @(negedge clock);

    // Reset during data bit 4 with an unconsumed byte pending.
    fork
      send_frame(8'hC3, 1'b1, 1'b0);
      begin
        repeat (4 * 16 + 8) @(negedge clock);
        check("pre_reset_busy", 32'(rx_if.busy), 32'h1);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(rx_if.valid), 32'h0);
        check("midrst_byte", 32'(rx_if.byte_received), 32'h0);
        check("midrst_busy", 32'(rx_if.busy), 32'h0);
        check("midrst_fe_ovr", 32'({rx_if.framing_error, rx_if.overrun}), 32'h0);
      end
    join
    reset = 1'b0;
    repeat (4) @(negedge clock);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("post_reset_byte", 32'(rx_if.byte_received), 32'h5A);
    check("post_reset_valid", 32'(rx_if.valid), 32'h1);

    repeat (20) @(negedge clock);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver: 8N1 frames, LSB first, idle-high line, same bit timing as the existing UART transmitter (`clocks_per_bit` clocks per bit). It consumes the serial line a `uart` transmitter drives. It sits between the board's RX pin and the command parser, delivering bytes on a valid/ack handshake. Input is synchronised internally. Each bit is decided by a 3-sample majority vote at mid-bit.

## Interface

- `clocks_per_bit`, default 16: system clocks per serial bit; minimum 4. `mid` = `clocks_per_bit/2`, using integer division.

- `clock`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `pin`  input  1  raw serial line; asynchronous to `clock`.
- `byte_received`  output  8  last good byte; changes only when a new byte is delivered.
- `valid`  output  1  high while `byte_received` is unconsumed.
- `ack`  input  1  consumer accepts the byte; only meaningful while `valid` is high.
- `framing_error`  output  1  one-cycle pulse when a stop bit samples low.
- `overrun`  output  1  one-cycle pulse when a byte is delivered over an unacked one.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation

- **Synchroniser:** two flops on `pin`, both reset to 1. All logic uses the second flop output, `rx_s`.
- **Reset values:** `byte_received`=0, `valid`=0, `framing_error`=0, `overrun`=0, `busy`=0. State=IDLE; counters and shift register at 0.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **Bit counter `clocks`:** counts 0..`clocks_per_bit`-1 and wraps to 0.
  - Samples of `rx_s` are taken in the cycles where `clocks` is `mid`-1, `mid` and `mid`+1.
  - The vote is the majority of the three samples. It is evaluated at the end of the `clocks`==`mid`+1 cycle.
- **IDLE:** when `rx_s`==0, go to START with `clocks` cleared to 0.
- **START:**
  - Vote=1 is a false start: return to IDLE. No output changes.
  - Vote=0: stay in START. At `clocks`==`clocks_per_bit`-1, go to DATA with `bit_index` cleared to 0.
- **DATA:**
  - The vote shifts into the shift register, LSB first.
  - At the end of each bit period, increment `bit_index`.
  - After bit 7's period ends, go to STOP.
- **STOP:** the vote is the stop bit. The state leaves STOP at the vote, without waiting for the bit period to end, so the receiver re-arms early.
  - Vote=1: `byte_received` takes the shift register and `valid` is set; go to IDLE.
  - Vote=1 with `valid` already high and no `ack` that cycle: additionally pulse `overrun`. The new byte overwrites the old one.
  - Vote=0: pulse `framing_error`, deliver nothing, go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`==1, then go to IDLE. This keeps a break condition from being read as a stream of 0x00 frames.
- **Handshake:**
  - `ack` high while `valid` is high clears `valid` on the next edge.
  - `ack` while `valid` is low is ignored.
  - A delivery and an `ack` in the same cycle leave `valid` at 1 with the new byte, and no `overrun`.
- **Reset mid-frame:** all state returns to reset values immediately. A partially received byte is discarded.

## Timing

- Let T be the rising edge at which IDLE sees `rx_s`==0. START is entered at T with `clocks`=0.
- `pin` falling edge to T: 2 to 3 clocks, due to the synchroniser.
- Bit n (start=0, data=1..8, stop=9) votes at edge T + n·`clocks_per_bit` + `mid` + 2.
- `valid`, `byte_received` and `overrun` update at edge T + 9·`clocks_per_bit` + `mid` + 2.
- `framing_error` is high for exactly the one cycle following that same edge.
- `busy` rises at T and falls when the state enters IDLE.
- Back-to-back frames with zero idle time are received without loss: re-arm occurs about half a bit before the next start edge.
- Tolerated baud mismatch: about ±4% accumulated over a frame.

## Test plan

All scenarios use `clocks_per_bit`=16, so `mid`=8.

- **Good frame:** drive byte 0xA5 on `pin` (start, 1,0,1,0,0,1,0,1, stop) -> `valid` rises at T+154, `byte_received`=0xA5. Pulse `ack` -> `valid` falls next edge.
- **Glitch:** drive `pin` low for 4 clocks, then high -> START aborts at vote, `busy` high for about 10 clocks, then `valid`, `framing_error` and `overrun` all stay 0.
- **Framing error:** send 0x3C with the stop bit held low, then keep the line low for 40 clocks -> `framing_error` pulses once, `valid` stays 0. No new frame starts until `pin` returns high.
- **Noise tolerance:** send 0x00 with a single-cycle high spike at `clocks`==`mid` of every data bit -> `byte_received`=0x00.
- **Overrun and simultaneity:** send 0x11 then 0x22 back to back with no `ack` -> `overrun` pulses at the second delivery and `byte_received`=0x22. Repeat with `ack` coinciding with the second delivery -> `valid` stays 1 and no `overrun` pulse.
- **Reset mid-frame:** assert `reset` during data bit 4 -> all outputs go to 0 asynchronously. A following good 0x5A frame is received correctly.
